md_sequencer: RTL and testbench

Multi-cycle sequencer for the EX-stage M-extension units. It accepts one RV32M operation from the ID/EX register and pulses the start of the iterative multiply unit (MU) or divide unit (DU). It stalls the pipeline until the unit reports done, then presents the result to the EX result mux for exactly one cycle. Divide special cases (divide-by-zero, signed overflow) are resolved locally without starting the DU. Pipeline flushes abort the operation cleanly.

---
 rtl/md_sequencer_if.sv | 36 +++
 rtl/md_sequencer.sv | 104 ++++++++++
 tb/tb_md_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/md_sequencer_if.sv
// md_sequencer_if: ID/EX issue, EX result and MU/DU handshake bundle for md_sequencer
interface md_sequencer_if;
  logic        issue_valid;
  logic [2:0]  issue_func3;
  logic [31:0] issue_rs1;
  logic [31:0] issue_rs2;
  logic        flush;
  logic        ex_stall;
  logic        res_valid;
  logic [31:0] res_data;
  logic        md_illegal;
  logic        mu_start;
  logic [1:0]  mu_ctl;
  logic [31:0] mu_a;
  logic [31:0] mu_b;
  logic        mu_done;
  logic [31:0] mu_result;
  logic        du_start;
  logic [1:0]  du_ctl;
  logic [31:0] du_a;
  logic [31:0] du_b;
  logic        du_done;
  logic [31:0] du_result;
  modport master (
    output issue_valid, issue_func3, issue_rs1, issue_rs2, flush,
    output mu_done, mu_result, du_done, du_result,
    input  ex_stall, res_valid, res_data, md_illegal,
    input  mu_start, mu_ctl, mu_a, mu_b, du_start, du_ctl, du_a, du_b
  );
  modport slave (
    input  issue_valid, issue_func3, issue_rs1, issue_rs2, flush,
    input  mu_done, mu_result, du_done, du_result,
    output ex_stall, res_valid, res_data, md_illegal,
    output mu_start, mu_ctl, mu_a, mu_b, du_start, du_ctl, du_a, du_b
  );
endinterface

// File: rtl/md_sequencer.sv
// md_sequencer: RV32M EX-stage sequencer for the iterative MU/DU.
// Define MD_DIV_EN for the divide path; otherwise divide ops complete as illegal.
module md_sequencer (
  input  logic          clk,
  input  logic          rst_n,
  md_sequencer_if.slave md
);
`ifdef MD_DIV_EN
  typedef enum logic [2:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE, DRAIN} state_t;
`else
  typedef enum logic [2:0] {IDLE, MUL_WAIT, DONE, DRAIN} state_t;
`endif
  state_t      state_q, state_d;
  logic [2:0]  func_q, func_d;
  logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic        mu_start_q, mu_start_d, du_start_q, du_start_d, illegal_q, illegal_d;
  logic        accept, sel_done;
  assign accept   = state_q == IDLE && md.issue_valid && !md.flush;
  // func_q[2] remembers which unit owns the op, also while draining
  assign sel_done = func_q[2] ? md.du_done : md.mu_done;
`ifdef MD_DIV_EN
  logic div_zero, div_ovf;
  assign div_zero = md.issue_rs2 == '0;
  assign div_ovf  = !md.issue_func3[0] && md.issue_rs1 == 32'h8000_0000 && md.issue_rs2 == 32'hFFFF_FFFF;
`endif
  always_comb begin
    state_d    = state_q;
    func_d     = func_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    illegal_d  = illegal_q;
    mu_start_d = 1'b0;
    du_start_d = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        func_d    = md.issue_func3;
        a_d       = md.issue_rs1;
        b_d       = md.issue_rs2;
        illegal_d = 1'b0;
        if (!md.issue_func3[2]) begin
          mu_start_d = 1'b1;
          state_d    = MUL_WAIT;
        end
`ifdef MD_DIV_EN
        else if (div_zero) begin
          res_d   = md.issue_func3[1] ? md.issue_rs1 : '1;
          state_d = DONE;
        end else if (div_ovf) begin
          res_d   = md.issue_func3[1] ? '0 : md.issue_rs1;
          state_d = DONE;
        end else begin
          du_start_d = 1'b1;
          state_d    = DIV_WAIT;
        end
`else
        else begin
          res_d     = '0;
          illegal_d = 1'b1;
          state_d   = DONE;
        end
`endif
      end
      DONE:  state_d = IDLE;
      DRAIN: state_d = sel_done ? IDLE : DRAIN;
      default: begin
        if (sel_done && !md.flush) res_d = func_q[2] ? md.du_result : md.mu_result;
        state_d = sel_done ? (md.flush ? IDLE : DONE) : (md.flush ? DRAIN : state_q);
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      func_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      illegal_q  <= 1'b0;
      mu_start_q <= 1'b0;
      du_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      func_q     <= func_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      illegal_q  <= illegal_d;
      mu_start_q <= mu_start_d;
      du_start_q <= du_start_d;
    end
  assign md.ex_stall   = md.issue_valid && state_q != DONE;
  assign md.res_valid  = state_q == DONE && !md.flush;
  assign md.res_data   = res_q;
  assign md.md_illegal = illegal_q;
  assign md.mu_start   = mu_start_q;
  assign md.du_start   = du_start_q;
  assign md.mu_ctl     = func_q[1:0];
  assign md.du_ctl     = func_q[1:0];
  assign md.mu_a       = a_q;
  assign md.mu_b       = b_q;
  assign md.du_a       = a_q;
  assign md.du_b       = b_q;
endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: vector table plus hand sequences for md_sequencer with a result scoreboard.
// Expectations follow MD_DIV_EN the same way as the design build.
module tb_md_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  md_sequencer_if m();
  md_sequencer dut (.clk(clk), .rst_n(rst_n), .md(m));
`ifdef MD_DIV_EN
  localparam logic [2:0] FW = 3'b101;
`else
  localparam logic [2:0] FW = 3'b000;
`endif
  typedef struct {
    logic [2:0]  f3;
    logic [31:0] rs1, rs2, ures, exp_res;
    int          lat, exp_lat, exp_mu, exp_du;
    bit          ill, spur;
  } vec_t;
  typedef struct packed {
    logic        ill;
    logic [31:0] res;
  } exp_t;
  vec_t tbl[$];
  exp_t exp_q[$];
  int errs = 0, checks = 0;
  int unit_lat = 0;
  logic [31:0] unit_res = '0;
  bit spur_du = 1'b0;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic add(input logic [2:0] f3, input logic [31:0] rs1, rs2, input int lat,
                     input logic [31:0] ures, exp_res, input bit ill, input int exp_lat, mu, du, input bit spur);
    vec_t v;
    v.f3 = f3; v.rs1 = rs1; v.rs2 = rs2; v.lat = lat; v.ures = ures; v.exp_res = exp_res;
    v.ill = ill; v.exp_lat = exp_lat; v.exp_mu = mu; v.exp_du = du; v.spur = spur;
    tbl.push_back(v);
  endtask
  // MU/DU behavioural model: done k cycles after the observed start
  int mu_cnt = 0, du_cnt = 0;
  bit mu_pend = 1'b0, du_pend = 1'b0;
  initial begin
    m.mu_done = 1'b0; m.du_done = 1'b0; m.mu_result = '0; m.du_result = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin mu_pend = 1'b0; du_pend = 1'b0; end
      if (m.mu_start) begin mu_pend = 1'b1; mu_cnt = unit_lat; end
      if (m.du_start) begin du_pend = 1'b1; du_cnt = unit_lat; end
      m.mu_done   = mu_pend && mu_cnt == 0;
      m.du_done   = (du_pend && du_cnt == 0) || (spur_du && mu_pend && mu_cnt != 0);
      m.mu_result = m.mu_done ? unit_res : '0;
      m.du_result = m.du_done ? (du_pend ? unit_res : 32'hDEAD_BEEF) : '0;
      if (mu_pend) begin if (mu_cnt == 0) mu_pend = 1'b0; else mu_cnt--; end
      if (du_pend) begin if (du_cnt == 0) du_pend = 1'b0; else du_cnt--; end
    end
  end
  // scoreboard monitor
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (m.mu_start || m.du_start) chk("start_exclusive", {31'b0, m.mu_start & m.du_start}, 32'd0);
    if (m.res_valid) begin
      chk("res_expected", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("res_data", m.res_data, e.res);
        chk("md_illegal", {31'b0, m.md_illegal}, {31'b0, e.ill});
      end
    end
  end
  task automatic run_op(input vec_t v);
    exp_t e;
    int nres, stalls, mus, dus;
    unit_lat = v.lat; unit_res = v.ures; spur_du = v.spur;
    m.issue_valid = 1'b1; m.issue_func3 = v.f3; m.issue_rs1 = v.rs1; m.issue_rs2 = v.rs2;
    e.ill = v.ill; e.res = v.exp_res;
    exp_q.push_back(e);
    nres = -1; stalls = 0; mus = 0; dus = 0;
    for (int n = 0; n < 60 && nres < 0; n++) begin
      @(negedge clk);
      stalls += int'(m.ex_stall);
      mus += int'(m.mu_start);
      dus += int'(m.du_start);
      if (m.mu_start || m.du_start) begin
        chk("op_a", m.mu_a, v.rs1);
        chk("op_b", m.du_b, v.rs2);
        chk("ctl", {28'b0, m.mu_ctl, m.du_ctl}, {28'b0, v.f3[1:0], v.f3[1:0]});
        chk("start_cycle", n, 1);
      end
      if (m.res_valid) nres = n;
      @(posedge clk); #1;
    end
    m.issue_valid = 1'b0;
    spur_du = 1'b0;
    chk("res_latency", nres, v.exp_lat);
    chk("stall_cycles", stalls, v.exp_lat);
    chk("mu_starts", mus, v.exp_mu);
    chk("du_starts", dus, v.exp_du);
  endtask
  initial begin
    vec_t fin;
    int rv;
    bit got_done;
    m.issue_valid = 1'b0; m.issue_func3 = '0; m.issue_rs1 = '0; m.issue_rs2 = '0; m.flush = 1'b0;
    add(3'b000, 32'd7, 32'd6, 3, 32'd42, 32'd42, 0, 5, 1, 0, 0);
`ifdef MD_DIV_EN
    add(3'b100, 32'd100, 32'd0, 0, 32'h0, 32'hFFFF_FFFF, 0, 1, 0, 0, 0);
    add(3'b111, 32'd100, 32'd0, 0, 32'h0, 32'd100, 0, 1, 0, 0, 0);
    add(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0, 32'h8000_0000, 0, 1, 0, 0, 0);
    add(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h1, 32'h0, 0, 1, 0, 0, 0);
    add(3'b101, 32'd100, 32'd7, 4, 32'd14, 32'd14, 0, 6, 0, 1, 0);
    add(3'b110, 32'hFFFF_FFF9, 32'd2, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 4, 0, 1, 0);
    add(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0, 32'h0, 0, 2, 0, 1, 0);
`else
    add(3'b110, 32'd100, 32'd7, 0, 32'h0, 32'h0, 1, 1, 0, 0, 0);
    add(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0, 32'h0, 1, 1, 0, 0, 0);
    add(3'b101, 32'd100, 32'd0, 0, 32'h0, 32'h0, 1, 1, 0, 0, 0);
`endif
    add(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 0, 5, 1, 0, 1);
    add(3'b001, 32'h1234_5678, 32'd9, 0, 32'h0A3D_70A3, 32'h0A3D_70A3, 0, 2, 1, 0, 0);
    add(3'b010, 32'd5, 32'd6, 5, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 7, 1, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'b0, m.ex_stall}, 32'd0);
    chk("rst_res_valid", {31'b0, m.res_valid}, 32'd0);
    chk("rst_res_data", m.res_data, 32'd0);
    chk("rst_starts_ill", {29'b0, m.mu_start, m.du_start, m.md_illegal}, 32'd0);
    chk("rst_operands", m.mu_a | m.mu_b | m.du_a | m.du_b, 32'd0);
    chk("rst_ctl", {28'b0, m.mu_ctl, m.du_ctl}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < tbl.size(); i++) run_op(tbl[i]);
    // flush while idle must not accept
    m.issue_valid = 1'b1; m.issue_func3 = 3'b000; m.issue_rs1 = 32'd1; m.issue_rs2 = 32'd1; m.flush = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_flush_start", {30'b0, m.mu_start, m.du_start}, 32'd0);
      @(posedge clk); #1;
    end
    m.issue_valid = 1'b0; m.flush = 1'b0;
    // flush two cycles after accept, unit done ten cycles later
    unit_lat = 9; unit_res = 32'h5555_5555;
    m.issue_valid = 1'b1; m.issue_func3 = FW; m.issue_rs1 = 32'd100; m.issue_rs2 = 32'd7;
    @(posedge clk); #1;
    @(posedge clk); #1;
    m.flush = 1'b1; m.issue_valid = 1'b0;
    @(posedge clk); #1;
    m.flush = 1'b0;
    rv = 0; got_done = 1'b0;
    for (int n = 0; n < 40 && !got_done; n++) begin
      @(negedge clk); #1;
      rv += int'(m.res_valid);
      got_done = m.mu_done || m.du_done;
    end
    chk("drain_done_seen", {31'b0, got_done}, 32'd1);
    chk("drain_no_res", rv, 0);
    @(posedge clk); #1;
    fin.f3 = 3'b000; fin.rs1 = 32'd9; fin.rs2 = 32'd9; fin.lat = 1; fin.ures = 32'd81; fin.exp_res = 32'd81;
    fin.ill = 1'b0; fin.exp_lat = 3; fin.exp_mu = 1; fin.exp_du = 0; fin.spur = 1'b0;
    run_op(fin);
    // flush in DONE suppresses res_valid
    unit_lat = 0; unit_res = 32'd15;
    m.issue_valid = 1'b1; m.issue_func3 = 3'b000; m.issue_rs1 = 32'd3; m.issue_rs2 = 32'd5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    m.flush = 1'b1;
    @(negedge clk);
    chk("done_flush_res_valid", {31'b0, m.res_valid}, 32'd0);
    chk("done_flush_stall", {31'b0, m.ex_stall}, 32'd0);
    @(posedge clk); #1;
    m.flush = 1'b0; m.issue_valid = 1'b0;
    // asynchronous reset in the middle of a wait
    unit_lat = 20; unit_res = 32'h0;
    m.issue_valid = 1'b1; m.issue_func3 = FW; m.issue_rs1 = 32'h1234; m.issue_rs2 = 32'h77;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0; m.issue_valid = 1'b0;
    #1;
    chk("arst_outputs", m.res_data | m.mu_a | m.mu_b | m.du_a | m.du_b, 32'd0);
    chk("arst_flags", {25'b0, m.ex_stall, m.res_valid, m.md_illegal, m.mu_start, m.du_start, m.mu_ctl[0], m.du_ctl[0]}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    fin.lat = 2; fin.ures = 32'h0000_0100; fin.exp_res = 32'h0000_0100; fin.exp_lat = 4;
    fin.rs1 = 32'd16; fin.rs2 = 32'd16;
    run_op(fin);
    repeat (2) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
